// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter sharing one 64-bit result path between
// four requesters through a valid/ready handshake. A registered grant drives
// the select of an internal mux4 instance.
// Optional feature: define ARB_LOCK_EN to let a requester hold its grant for
// up to MAX_LOCK consecutive beats while it asserts req_lock.

module mux4 #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] out
);

  // Plain 4:1 select
  always_comb begin
    out = in0;
    case (sel)
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

module mux4_arbiter #(
  parameter int MAX_LOCK = 8,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        req_valid,
  input  logic [3:0]        req_lock,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        req_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        sel,
  output logic [3:0]        gnt,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] sel_nx;
  logic [3:0] gnt_nx;
  logic [1:0] last;
  logic [1:0] last_nx;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       xfer;
  logic       drop;
  logic       hold_lock;

  // A beat moves when the granted requester is valid and the consumer is ready
  assign xfer = (state == GRANT) && req_valid[sel] && out_ready;
  // Granted requester withdrew its valid without transferring: give up the grant
  assign drop = (state == GRANT) && !req_valid[sel];

  // Round-robin pick: scan last+4 down to last+1 so the nearest set bit wins
  always_comb begin
    pick = last + 2'd1;
    cand = last;
    for (int k = 3; k >= 0; k--) begin
      cand = last + 2'(k + 1);
      if (req_valid[cand]) pick = cand;
    end
  end

`ifdef ARB_LOCK_EN
  localparam int                CNT_W    = ($clog2(MAX_LOCK) < 3) ? 3 : $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_LOCK - 1);

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nx;

  // Keep the grant only while locking and the burst has beats left
  assign hold_lock = req_lock[sel] && (beat_cnt < CNT_LAST);

  // Beat counter for the current locked burst; stalls leave it untouched
  always_comb begin
    beat_cnt_nx = beat_cnt;
    if (xfer && hold_lock)
      beat_cnt_nx = beat_cnt + 1'b1;
    else if (xfer || drop)
      beat_cnt_nx = '0;
  end

  // Beat counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) beat_cnt <= '0;
    else          beat_cnt <= beat_cnt_nx;
  end
`else
  logic [3:0]  unused_lock;
  logic [31:0] unused_max;

  // Without the lock feature every grant is a single transfer
  assign hold_lock   = 1'b0;
  assign unused_lock = req_lock;
  assign unused_max  = MAX_LOCK;
`endif

  // State, grant and priority pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      last  <= 2'd3;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
    end
  end

  // Next-state logic: grant on any request in IDLE, release on transfer or drop
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    gnt_nx   = gnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        gnt_nx = 4'b0000;
        if (|req_valid) begin
          state_nx = GRANT;
          sel_nx   = pick;
          gnt_nx   = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if ((xfer && !hold_lock) || drop) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          last_nx  = sel;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
      end
    endcase
  end

  // Handshake outputs derived from the registered grant and live inputs
  always_comb begin
    busy      = (state == GRANT);
    out_valid = 1'b0;
    req_ready = 4'b0000;
    if (state == GRANT) begin
      out_valid = req_valid[sel];
      req_ready = out_ready ? (4'b0001 << sel) : 4'b0000;
    end
  end

  mux4 #(.DATA_W(DATA_W)) u_mux4 (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel),
    .out (out_data)
  );

endmodule

// File: tb/tb_mux4_arbiter.sv
// Testbench for mux4_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level round-robin model.

module tb_mux4_arbiter;

  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [63:0] din [4];
  logic [3:0]  req_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who holds the grant, who was released last, beats so far
  bit m_busy;
  int m_sel;
  int m_last;
  int m_beats;
  int xfer_log[$];

  always #5 clk = ~clk;

  mux4_arbiter #(.MAX_LOCK(MAX_LOCK), .DATA_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_sel   = 0;
    m_last  = 3;
    m_beats = 0;
  endtask

  task automatic model_release();
    m_last  = m_sel;
    m_busy  = 1'b0;
    m_beats = 0;
  endtask

  // Compare every visible output with what the model says right now
  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_sel) : 4'b0000;
    check_eq({tag, ".gnt"},  64'(gnt),  64'(eg));
    check_eq({tag, ".busy"}, 64'(busy), 64'(m_busy));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(m_busy && req_valid[m_sel]));
    check_eq({tag, ".req_ready"}, 64'(req_ready), 64'((m_busy && out_ready) ? eg : 4'b0000));
    if (m_busy) begin
      check_eq({tag, ".sel"},      64'(sel), 64'(m_sel));
      check_eq({tag, ".out_data"}, out_data, din[m_sel]);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_advance();
    int idx;
    if (!m_busy) begin
      if (req_valid != 4'b0000) begin
        for (int k = 4; k >= 1; k--) begin
          idx = (m_last + k) % 4;
          if (req_valid[idx]) m_sel = idx;
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req_valid[m_sel]) begin
      model_release();
    end else if (out_ready) begin
      xfer_log.push_back(m_sel);
`ifdef ARB_LOCK_EN
      if (req_lock[m_sel] && (m_beats < MAX_LOCK - 1)) m_beats++;
      else model_release();
`else
      model_release();
`endif
    end
  endtask

  // One clock: check mid-cycle, then move the model across the edge
  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    model_reset();
    #1;
    check_eq("rst.gnt",       64'(gnt),       64'h0);
    check_eq("rst.sel",       64'(sel),       64'h0);
    check_eq("rst.busy",      64'(busy),      64'h0);
    check_eq("rst.out_valid", 64'(out_valid), 64'h0);
    check_eq("rst.req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    xfer_log.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 64'h0;
    do_reset();

    // Single requester 2
    req_valid = 4'b0100;
    din[2]    = 64'hDEAD_BEEF_0000_0002;
    out_ready = 1'b1;
    step("single_idle");
    @(negedge clk);
    check_eq("single.gnt",       64'(gnt),       64'h4);
    check_eq("single.sel",       64'(sel),       64'h2);
    check_eq("single.out_data",  out_data,       64'hDEAD_BEEF_0000_0002);
    check_eq("single.req_ready", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    model_advance();
    step("single_release");

    // All four requesting: order 0,1,2,3,0 with an idle bubble between
    do_reset();
    din[0] = 64'h0000_0000_AAAA_0000;
    din[1] = 64'h1111_1111_AAAA_0001;
    din[2] = 64'h2222_2222_AAAA_0002;
    din[3] = 64'h3333_3333_AAAA_0003;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (10) step("all4");
    check_eq("all4.count", 64'(xfer_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < xfer_log.size(); i++)
      check_eq("all4.order", 64'(xfer_log[i]), 64'(i % 4));

    // Backpressure on requester 1; requester 3 shows up mid-stall
    do_reset();
    req_valid = 4'b0010;
    out_ready = 1'b0;
    step("bp_idle");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_valid = 4'b1010;
      step("bp_stall");
    end
    out_ready = 1'b1;
    step("bp_go");
    check_eq("bp.count", 64'(xfer_log.size()), 64'd1);
    if (xfer_log.size() > 0) check_eq("bp.src", 64'(xfer_log[0]), 64'd1);
    repeat (3) step("bp_after");

    // Lock request from requester 0 with requester 1 also pending
    do_reset();
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    out_ready = 1'b1;
    repeat (20) step("lock");
`ifdef ARB_LOCK_EN
    check_eq("lock.min_count", 64'(xfer_log.size() >= 9), 64'd1);
    for (int i = 0; i < 9 && i < xfer_log.size(); i++)
      check_eq("lock.order", 64'(xfer_log[i]), 64'((i < 8) ? 0 : 1));
`else
    check_eq("lock.min_count", 64'(xfer_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++)
      check_eq("lock.order", 64'(xfer_log[i]), 64'(i % 2));
`endif
    req_lock = 4'b0000;

    // Requester 3 drops valid before the consumer is ready
    do_reset();
    req_valid = 4'b1000;
    step("drop_idle");
    req_valid = 4'b0110;
    step("drop_release");
    step("drop_regrant");
    out_ready = 1'b1;
    step("drop_xfer");
    check_eq("drop.count", 64'(xfer_log.size()), 64'd1);
    if (xfer_log.size() > 0) check_eq("drop.src", 64'(xfer_log[0]), 64'd1);

    // Asynchronous reset in the middle of a grant
    do_reset();
    req_valid = 4'b0001;
    out_ready = 1'b1;
    step("mid_idle");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst.gnt",       64'(gnt),       64'h0);
    check_eq("midrst.req_ready", 64'(req_ready), 64'h0);
    check_eq("midrst.out_valid", 64'(out_valid), 64'h0);
    check_eq("midrst.busy",      64'(busy),      64'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    xfer_log.delete();
    req_valid = 4'b1111;
    repeat (2) step("midrst_after");
    check_eq("midrst.first", 64'(xfer_log.size() > 0 ? xfer_log[0] : -1), 64'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_lock  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) din[i] = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rnd_rst.busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
